// File: rtl/ram_stream_loader.sv
// Packs a 16-bit valid/ready beat stream into 64-bit words and writes them to the
// IO-module dual-read RAM at consecutive addresses from a programmable base.
module ram_stream_loader #(
  parameter int ADDRESS_WIDTH = 13,
  parameter int DATA_WIDTH    = 64,
  parameter int IN_WIDTH      = 16,
  parameter int BEATS         = 4,
  parameter int DEPTH         = 16
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           start,
  input  logic [ADDRESS_WIDTH-1:0]       base_addr,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [IN_WIDTH-1:0]            in_data,
  input  logic                           in_last,
  output logic                           WR_Enable,
  output logic [ADDRESS_WIDTH-1:0]       address_WR,
  output logic [DATA_WIDTH-1:0]          dataIn,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(DEPTH+1)-1:0]     word_count,
  output logic                           overflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
  localparam logic [BW-1:0] LAST_BEAT_C = BW'(BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_FINISH
  } state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0]    pack_p0;
  logic [DATA_WIDTH-1:0]    pack_nxt;
  logic [BW-1:0]            beat_idx_p0;
  logic [ADDRESS_WIDTH-1:0] wr_ptr;
  logic                     last_word;
  logic                     xfer;
  logic                     full;
  logic                     closing;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == DEPTH_C) ? v : v + 1'b1;
  endfunction

  assign in_ready = (state == S_COLLECT);
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_FINISH);

  assign xfer    = in_valid && in_ready;
  assign full    = (word_count == DEPTH_C);
  assign closing = xfer && !full && ((beat_idx_p0 == LAST_BEAT_C) || in_last);

  // Word under construction with the current beat inserted; the first beat lands lowest.
  always_comb begin
    pack_nxt = pack_p0;
    pack_nxt[IN_WIDTH*beat_idx_p0 +: IN_WIDTH] = in_data;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_COLLECT;
      S_COLLECT: begin
        if (xfer) begin
          if (full) begin
            if (in_last) state_nxt = S_FINISH;
          end else if (closing) begin
            state_nxt = S_WRITE;
          end
        end
      end
      S_WRITE:   state_nxt = last_word ? S_FINISH : S_COLLECT;
      S_FINISH:  state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Write strobe, address and data are registered on the edge that accepts the
  // closing beat, so they are presented to the RAM during the WRITE cycle.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      WR_Enable   <= 1'b0;
      address_WR  <= '0;
      dataIn      <= '0;
      word_count  <= '0;
      overflow    <= 1'b0;
      pack_p0     <= '0;
      beat_idx_p0 <= '0;
      wr_ptr      <= '0;
      last_word   <= 1'b0;
    end else begin
      WR_Enable <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            wr_ptr      <= base_addr;
            word_count  <= '0;
            overflow    <= 1'b0;
            pack_p0     <= '0;
            beat_idx_p0 <= '0;
            last_word   <= 1'b0;
          end
        end
        S_COLLECT: begin
          if (xfer) begin
            if (full) begin
              overflow <= 1'b1;
            end else if (closing) begin
              WR_Enable  <= 1'b1;
              address_WR <= wr_ptr;
              dataIn     <= pack_nxt;
              last_word  <= in_last;
              pack_p0    <= pack_nxt;
            end else begin
              pack_p0     <= pack_nxt;
              beat_idx_p0 <= beat_idx_p0 + 1'b1;
            end
          end
        end
        S_WRITE: begin
          wr_ptr      <= wr_ptr + 1'b1;
          word_count  <= sat_inc(word_count);
          pack_p0     <= '0;
          beat_idx_p0 <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
